// File: rtl/im_loader.sv
// im_loader: boot-time initiator that fills the instruction memory.
// Packs a valid/ready byte stream into big-endian 32-bit words, writes
// them to consecutive word addresses, and optionally reads each one back.
//
// Ports:
//   clk         system clock, all state updates on posedge
//   reset       synchronous active-low reset
//   start       begin a load (sampled only while idle)
//   word_count  number of words to load, latched on start
//   byte_in     stream data
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte (collecting bytes)
//   im_addr     byte address to the instruction memory
//   im_wdata    write data to the instruction memory
//   im_cs       instruction memory chip select
//   im_wr       instruction memory write strobe
//   im_rd       instruction memory read strobe
//   im_rdata    instruction memory read data (combinational)
//   busy        high whenever not idle
//   done        one-cycle pulse at the end of a load
//   error       sticky verify/range error, cleared by the next start
//   err_addr    address of the first failing word
module im_loader #(
   parameter logic [11:0] BASE_ADDR = 12'h000,
   parameter bit          VERIFY    = 1'b1,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] word_count,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [11:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        im_cs,
   output logic        im_wr,
   output logic        im_rd,
   input  logic [31:0] im_rdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [11:0] err_addr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_CHECK,
      S_DONE
   } state_t;

   // Word alignment of the base address is enforced here.
   localparam logic [11:0] BASE = {BASE_ADDR[11:2], 2'b00};
   localparam logic [11:0] MAXW = 12'(MAX_WORDS);

   state_t      r_state;
   logic [1:0]  r_bcnt;
   logic [10:0] r_wcnt;
   logic [31:0] r_wdata;
   logic [11:0] r_addr;
   logic [11:0] r_err_addr;
   logic        r_error;

   logic        w_last;
   logic        w_too_big;
   state_t      w_after;

   // Remaining count of 1 means the word just handled was the last one.
   assign w_last    = (r_wcnt == 11'd1);
   assign w_too_big = ({1'b0, word_count} > MAXW);
   assign w_after   = w_last ? S_DONE : S_COLLECT;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_bcnt     <= 2'd0;
         r_wcnt     <= 11'd0;
         r_wdata    <= 32'd0;
         r_addr     <= 12'd0;
         r_err_addr <= 12'd0;
         r_error    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_wcnt     <= word_count;
                  r_addr     <= BASE;
                  r_bcnt     <= 2'd0;
                  r_error    <= 1'b0;
                  r_err_addr <= 12'd0;
                  if (word_count == 11'd0) begin
                     r_state <= S_DONE;
                  end else if (w_too_big) begin
                     r_state    <= S_DONE;
                     r_error    <= 1'b1;
                     r_err_addr <= BASE;
                  end else begin
                     r_state <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (byte_valid) begin
                  // First byte of the word lands in the MSB.
                  unique case (r_bcnt)
                     2'd0: r_wdata[31:24] <= byte_in;
                     2'd1: r_wdata[23:16] <= byte_in;
                     2'd2: r_wdata[15:8]  <= byte_in;
                     2'd3: r_wdata[7:0]   <= byte_in;
                  endcase
                  r_bcnt <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     r_state <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (VERIFY) begin
                  r_state <= S_CHECK;
               end else begin
                  r_wcnt  <= r_wcnt - 11'd1;
                  r_addr  <= r_addr + 12'd4;
                  r_state <= w_after;
               end
            end
            S_CHECK: begin
               if (im_rdata != r_wdata) begin
                  // Abort: remaining words are not loaded.
                  r_error    <= 1'b1;
                  r_err_addr <= r_addr;
                  r_state    <= S_DONE;
               end else begin
                  r_wcnt  <= r_wcnt - 11'd1;
                  r_addr  <= r_addr + 12'd4;
                  r_state <= w_after;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake and memory strobes depend on the state register only.
   assign byte_ready = (r_state == S_COLLECT);
   assign im_cs      = (r_state == S_WRITE) || (r_state == S_CHECK);
   assign im_wr      = (r_state == S_WRITE);
   assign im_rd      = (r_state == S_CHECK);
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);

   assign im_addr  = r_addr;
   assign im_wdata = r_wdata;
   assign error    = r_error;
   assign err_addr = r_err_addr;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: scoreboard bench for im_loader.
// Two instances (base 0x000 and base 0xFFC) share one memory model.
module tb_im_loader;

   typedef struct {
      logic [11:0] a;
      logic [31:0] d;
      int          c;
   } wr_t;

   typedef struct {
      logic        e;
      logic [11:0] ea;
      int          c;
   } dn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        sel;
   logic [10:0] word_count;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic [31:0] m_rdata;

   logic        a_ready, a_cs, a_wr, a_rd, a_busy, a_done, a_error;
   logic [11:0] a_addr, a_err;
   logic [31:0] a_wdata;
   logic        b_ready, b_cs, b_wr, b_rd, b_busy, b_done, b_error;
   logic [11:0] b_addr, b_err;
   logic [31:0] b_wdata;

   logic        m_ready, m_cs, m_wr, m_rd, m_busy, m_done, m_error;
   logic [11:0] m_addr, m_err;
   logic [31:0] m_wdata;

   logic [7:0]  mem [4096];
   logic        mem_clr;
   logic        bad_en;
   logic [11:0] bad_addr;

   wr_t wq[$];
   dn_t dq[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  t0 = 0;
   int  cs_cnt = 0;
   bit  done_seen = 1'b0;

   im_loader #(
      .BASE_ADDR(12'h000), .VERIFY(1'b1), .MAX_WORDS(1024)
   ) u_a (
      .clk(clk), .reset(reset), .start(start & ~sel),
      .word_count(word_count), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(a_ready),
      .im_addr(a_addr), .im_wdata(a_wdata), .im_cs(a_cs),
      .im_wr(a_wr), .im_rd(a_rd), .im_rdata(m_rdata),
      .busy(a_busy), .done(a_done), .error(a_error),
      .err_addr(a_err)
   );

   im_loader #(
      .BASE_ADDR(12'hFFC), .VERIFY(1'b1), .MAX_WORDS(1024)
   ) u_b (
      .clk(clk), .reset(reset), .start(start & sel),
      .word_count(word_count), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(b_ready),
      .im_addr(b_addr), .im_wdata(b_wdata), .im_cs(b_cs),
      .im_wr(b_wr), .im_rd(b_rd), .im_rdata(m_rdata),
      .busy(b_busy), .done(b_done), .error(b_error),
      .err_addr(b_err)
   );

   assign m_ready = sel ? b_ready : a_ready;
   assign m_cs    = sel ? b_cs    : a_cs;
   assign m_wr    = sel ? b_wr    : a_wr;
   assign m_rd    = sel ? b_rd    : a_rd;
   assign m_busy  = sel ? b_busy  : a_busy;
   assign m_done  = sel ? b_done  : a_done;
   assign m_error = sel ? b_error : a_error;
   assign m_addr  = sel ? b_addr  : a_addr;
   assign m_err   = sel ? b_err   : a_err;
   assign m_wdata = sel ? b_wdata : a_wdata;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rdw(input logic [11:0] a);
      return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
   endfunction

   assign m_rdata = (bad_en && m_addr == bad_addr) ? 32'h0 : rdw(m_addr);

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      end else if (m_cs && m_wr) begin
         mem[m_addr]         <= m_wdata[31:24];
         mem[m_addr + 12'd1] <= m_wdata[23:16];
         mem[m_addr + 12'd2] <= m_wdata[15:8];
         mem[m_addr + 12'd3] <= m_wdata[7:0];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents a write or done.
   always @(negedge clk) begin
      wr_t w;
      dn_t d;
      if (m_cs) cs_cnt++;
      if (m_cs && m_wr) begin
         chk("rd_during_wr", m_rd, 0);
         chk("wr_expected", wq.size() != 0, 1);
         if (wq.size() != 0) begin
            w = wq.pop_front();
            chk("wr_addr", m_addr, w.a);
            chk("wr_data", m_wdata, w.d);
            chk("wr_cycle", cyc + 1 - t0, w.c);
         end
      end
      if (m_done) begin
         done_seen = 1'b1;
         chk("done_expected", dq.size() != 0, 1);
         if (dq.size() != 0) begin
            d = dq.pop_front();
            chk("done_error", m_error, d.e);
            chk("done_err_addr", m_err, d.ea);
            chk("done_cycle", cyc + 1 - t0, d.c);
         end
      end
   end

   task automatic exp_wr(input logic [11:0] a, input logic [31:0] d,
                         input int c);
      wr_t w;
      w.a = a;
      w.d = d;
      w.c = c;
      wq.push_back(w);
   endtask

   task automatic exp_dn(input logic e, input logic [11:0] ea, input int c);
      dn_t d;
      d.e  = e;
      d.ea = ea;
      d.c  = c;
      dq.push_back(d);
   endtask

   task automatic do_start(input logic [10:0] n);
      @(negedge clk);
      done_seen  = 1'b0;
      start      = 1'b1;
      word_count = n;
      @(posedge clk);
      #1;
      t0    = cyc;
      start = 1'b0;
   endtask

   task automatic feed(input logic [95:0] v, input int n, input bit gap);
      int i = 0;
      int g = 0;
      bit ph = 1'b0;
      bit acc;
      while (i < n && g < 200 && !done_seen) begin
         @(negedge clk);
         byte_in    = v[95 - 8*i -: 8];
         byte_valid = gap ? ph : 1'b1;
         ph         = ~ph;
         acc        = byte_valid & m_ready;
         @(posedge clk);
         if (acc) i++;
         g++;
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int k = 0;
      while (!done_seen && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk("done_timeout", done_seen, 1);
      chk("writes_left", wq.size(), 0);
      chk("dones_left", dq.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_mem();
      @(negedge clk);
      mem_clr = 1'b1;
      @(negedge clk);
      mem_clr = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int s;
      reset      = 1'b0;
      start      = 1'b0;
      sel        = 1'b0;
      word_count = 11'd0;
      byte_in    = 8'd0;
      byte_valid = 1'b0;
      bad_en     = 1'b0;
      bad_addr   = 12'd0;
      mem_clr    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state",
          {m_ready, m_addr, m_wdata, m_cs, m_wr, m_rd,
           m_busy, m_done, m_error, m_err}, 0);
      clear_mem();
      @(negedge clk);
      reset = 1'b1;

      // Basic load, back-to-back bytes.
      exp_wr(12'h000, 32'hDEADBEEF, 5);
      exp_wr(12'h004, 32'h01234567, 11);
      exp_dn(1'b0, 12'h000, 13);
      do_start(11'd2);
      chk("busy_ready_collect", {m_busy, m_ready, m_cs}, 3'b110);
      feed(96'hDEADBEEF_01234567_00000000, 8, 1'b0);
      wait_done(100);
      chk("mem_0", rdw(12'h000), 32'hDEADBEEF);
      chk("mem_4", rdw(12'h004), 32'h01234567);
      chk("idle_busy", m_busy, 0);

      // Backpressure: byte_valid on alternate cycles.
      clear_mem();
      exp_wr(12'h000, 32'hDEADBEEF, 9);
      exp_wr(12'h004, 32'h01234567, 19);
      exp_dn(1'b0, 12'h000, 21);
      do_start(11'd2);
      feed(96'hDEADBEEF_01234567_00000000, 8, 1'b1);
      wait_done(100);
      chk("bp_mem_0", rdw(12'h000), 32'hDEADBEEF);
      chk("bp_mem_4", rdw(12'h004), 32'h01234567);

      // Verify failure at address 4 aborts the load.
      clear_mem();
      bad_en   = 1'b1;
      bad_addr = 12'h004;
      exp_wr(12'h000, 32'h10203040, 5);
      exp_wr(12'h004, 32'h50607080, 11);
      exp_dn(1'b1, 12'h004, 13);
      do_start(11'd3);
      feed(96'h10203040_50607080_90A0B0C0, 12, 1'b0);
      wait_done(100);
      bad_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("sticky_error", {m_error, m_err, m_busy}, {1'b1, 12'h004, 1'b0});
      chk("no_write_at_8", rdw(12'h008), 32'h0);

      // Range edges.
      s = cs_cnt;
      exp_dn(1'b0, 12'h000, 1);
      do_start(11'd0);
      wait_done(20);
      chk("zero_no_cs", cs_cnt - s, 0);
      s = cs_cnt;
      exp_dn(1'b1, 12'h000, 1);
      do_start(11'd1025);
      wait_done(20);
      chk("over_no_cs", cs_cnt - s, 0);
      chk("over_error_held", m_error, 1);
      exp_wr(12'h000, 32'hCAFEF00D, 5);
      exp_dn(1'b0, 12'h000, 7);
      do_start(11'd1);
      chk("start_clears_error", m_error, 0);
      feed(96'hCAFEF00D_00000000_00000000, 4, 1'b0);
      wait_done(50);
      chk("max_words_ok", m_error, 0);

      // Address wrap on the 0xFFC-based instance.
      clear_mem();
      sel = 1'b1;
      exp_dn(1'b1, 12'hFFC, 1);
      do_start(11'd1025);
      wait_done(20);
      exp_wr(12'hFFC, 32'hA1B2C3D4, 5);
      exp_wr(12'h000, 32'h55667788, 11);
      exp_dn(1'b0, 12'h000, 13);
      do_start(11'd2);
      feed(96'hA1B2C3D4_55667788_00000000, 8, 1'b0);
      wait_done(100);
      chk("wrap_mem_ffc", rdw(12'hFFC), 32'hA1B2C3D4);
      chk("wrap_mem_000", rdw(12'h000), 32'h55667788);
      @(negedge clk);
      sel = 1'b0;

      // Reset in the middle of a word.
      clear_mem();
      do_start(11'd2);
      feed(96'h11220000_00000000_00000000, 2, 1'b0);
      chk("pre_reset_busy", m_busy, 1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_reset_outputs",
          {m_ready, m_addr, m_wdata, m_cs, m_wr, m_rd,
           m_busy, m_done, m_error, m_err}, 0);
      @(negedge clk);
      reset = 1'b1;
      chk("reset_no_write", rdw(12'h000), 32'h0);
      exp_wr(12'h000, 32'h11223344, 5);
      exp_dn(1'b0, 12'h000, 7);
      do_start(11'd1);
      feed(96'h11223344_00000000_00000000, 4, 1'b0);
      wait_done(50);
      chk("post_reset_mem", rdw(12'h000), 32'h11223344);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time initiator that fills the instruction memory over its write/read port.
- Accepts a byte stream with a valid/ready handshake and packs every four bytes into a 32-bit word, first byte in the MSB.
- Writes each word to the instruction memory at consecutive byte addresses, big-endian.
- Optionally reads each word back and compares it; reports done, error and the failing address to the control/test harness.

Parameters:
- BASE_ADDR, 12'h000: byte address of the first word. Low 2 bits are forced to 0.
- VERIFY, 1: 1 = read back and compare after every write; 0 = skip the readback.
- MAX_WORDS, 1024: largest legal word_count (a 4096-byte memory holds 1024 words).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE.
- word_count  input  11  number of words to load; latched on start.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte; high only in COLLECT.
- im_addr  output  12  byte address to the instruction memory.
- im_wdata  output  32  write data to the instruction memory.
- im_cs  output  1  instruction memory chip select.
- im_wr  output  1  instruction memory write strobe.
- im_rd  output  1  instruction memory read strobe.
- im_rdata  input  32  instruction memory read data. Combinational, valid while im_cs and im_rd are high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a load.
- error  output  1  sticky verify/range error flag; cleared by the next accepted start.
- err_addr  output  12  address of the first failing word.

Behaviour:
- Reset (reset=0 at posedge):
  - State goes to IDLE.
  - All outputs go to 0, as do the byte counter, the word counter and the partial-word register.
  - Reset has priority over every other event.
  - Reset mid-load discards the partial word. Words already written stay in memory.
- Control outputs:
  - im_cs, im_wr, im_rd, byte_ready, busy and done are decoded from the state register only (Moore).
  - im_addr, im_wdata and err_addr are registered.
- States:
  - IDLE:
    - On start=1: latch word_count, set im_addr=BASE_ADDR, clear error and err_addr.
    - word_count=0 -> DONE with no memory access.
    - word_count>MAX_WORDS -> DONE with error=1 and err_addr=BASE_ADDR.
    - Otherwise -> COLLECT.
  - COLLECT:
    - byte_ready=1. A byte is accepted on a posedge with byte_valid=1.
    - Byte k of the word (k=0..3) goes into bits [31-8k -: 8] of im_wdata.
    - After the 4th accepted byte -> WRITE. No acceptance occurs outside COLLECT.
  - WRITE: im_cs=1, im_wr=1 for exactly one cycle. Next state is CHECK if VERIFY=1, else ADVANCE.
  - CHECK:
    - im_cs=1, im_rd=1 for one cycle; im_rdata is compared with im_wdata at the posedge.
    - Mismatch -> error=1, err_addr=im_addr, go to DONE (abort; remaining words not loaded).
    - Match -> ADVANCE.
  - ADVANCE (internal, same cycle as the exit from WRITE/CHECK; no extra cycle):
    - Decrement the remaining count and add 4 to im_addr, modulo 4096 (wraps 4092 -> 0).
    - Remaining count 0 -> DONE, else COLLECT.
  - DONE: done=1 for one cycle, then IDLE. busy=1 in DONE.
- start while busy is ignored.
- With continuous byte_valid and VERIFY=1, each word takes 6 cycles (4 COLLECT, 1 WRITE, 1 CHECK). With VERIFY=0 it takes 5 cycles.
- The memory is never written twice for one word and is never read with im_wr=1.

Test Plan:
1. Basic load, VERIFY=1, BASE_ADDR=0, word_count=2, bytes DE AD BE EF 01 23 45 67 back-to-back, start accepted at cycle 0:
   - writes 32'hDEADBEEF at addr 0 (cycle 5) and 32'h01234567 at addr 4 (cycle 11);
   - memory bytes 0..7 = DE AD BE EF 01 23 45 67;
   - done pulses at cycle 13; error=0.
2. Backpressure: same stream with byte_valid low on alternate cycles -> byte_ready stays high throughout COLLECT, identical memory contents, no extra im_wr pulses, done at cycle 21.
3. Verify failure: memory model forces im_rdata=0 at addr 4, word_count=3:
   - error=1, err_addr=12'h004, done pulses;
   - no write ever occurs at addr 8.
4. Range edges:
   - word_count=0 -> done one cycle after start, im_cs never asserted, error=0.
   - word_count=1025 -> done with error=1, err_addr=BASE_ADDR.
   - The next start with word_count=1 clears error.
5. Wrap: BASE_ADDR=12'hFFC, word_count=2 -> writes at 12'hFFC then 12'h000, done, error=0.
6. Reset mid-load:
   - reset=0 after 2 bytes accepted -> next cycle all outputs are 0, state IDLE, no write issued.
   - A fresh start with bytes 11 22 33 44 writes 32'h11223344 at BASE_ADDR.
